mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_decode.sv | 40 ++++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller and its datapath:
// state codes, opcode/funct constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_MEM = 2'd1;
    localparam logic [1:0] WSRC_PC4 = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_PASSB = 3'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_ADDIU, I_LUI,
        I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
    } iclass_t;

    // R-type results go to rd; every other register write targets rt or $31.
    function automatic logic is_rtype(input iclass_t c);
        return (c == I_ADDU) || (c == I_SUBU);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps opcode/funct to an instruction
// class and drives the immediate-extender controls in every state.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       ext_sign_src,
    output logic       ext_lui
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        iclass = I_BAD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = I_ADDU;
                    FN_SUBU: iclass = I_SUBU;
                    FN_JR:   iclass = I_JR;
                    default: iclass = I_BAD;
                endcase
            end
            OP_ORI:   iclass = I_ORI;
            OP_ADDIU: iclass = I_ADDIU;
            OP_LUI:   iclass = I_LUI;
            OP_LW:    iclass = I_LW;
            OP_SW:    iclass = I_SW;
            OP_BEQ:   iclass = I_BEQ;
            OP_J:     iclass = I_J;
            OP_JAL:   iclass = I_JAL;
            default:  iclass = I_BAD;
        endcase
    end

    assign ext_sign_src = (opcode == OP_ORI);
    assign ext_lui      = (opcode == OP_LUI);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshake and datapath write-enable/select generation.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       mem_req,
    input  logic       mem_rdy,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic       mem_we,
    output logic [1:0] rf_dst,
    output logic [1:0] rf_wsrc,
    output logic       alu_srcb,
    output logic [2:0] alu_op,
    output logic       ext_sign_src,
    output logic       ext_lui,
    output logic [1:0] pc_src,
    output logic [2:0] state_o
);

    state_t  state;
    state_t  state_nxt;
    iclass_t iclass;
    logic    rdy;

    assign rdy     = MEM_WAIT_EN ? mem_rdy : 1'b1;
    assign state_o = state;

    mc_decode u_decode (
        .opcode       (opcode),
        .funct        (funct),
        .iclass       (iclass),
        .ext_sign_src (ext_sign_src),
        .ext_lui      (ext_lui)
    );

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        rf_dst    = DST_RT;
        rf_wsrc   = WSRC_ALU;
        alu_srcb  = 1'b0;
        alu_op    = ALU_ADD;
        pc_src    = PC_PLUS4;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (rdy) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (iclass)
                    I_ADDU:  state_nxt = S_WB;
                    I_SUBU: begin
                        alu_op    = ALU_SUB;
                        state_nxt = S_WB;
                    end
                    I_ORI: begin
                        alu_op    = ALU_OR;
                        alu_srcb  = 1'b1;
                        state_nxt = S_WB;
                    end
                    I_ADDIU: begin
                        alu_srcb  = 1'b1;
                        state_nxt = S_WB;
                    end
                    I_LUI: begin
                        alu_op    = ALU_PASSB;
                        alu_srcb  = 1'b1;
                        state_nxt = S_WB;
                    end
                    I_LW, I_SW: begin
                        alu_srcb  = 1'b1;
                        state_nxt = S_MEM;
                    end
                    I_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_we  = zero;
                        pc_src = PC_BRANCH;
                    end
                    I_J: begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                    I_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        rf_we   = 1'b1;
                        rf_dst  = DST_RA;
                        rf_wsrc = WSRC_PC4;
                    end
                    I_JR: begin
                        pc_we  = 1'b1;
                        pc_src = PC_REG;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (rdy) begin
                    if (iclass == I_SW) begin
                        mem_we    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_dst    = is_rtype(iclass) ? DST_RD : DST_RT;
                rf_wsrc   = (iclass == I_LW) ? WSRC_MEM : WSRC_ALU;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset silences the memory port and all writes in the cycle it is held.
        if (reset) begin
            mem_req = 1'b0;
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            rf_we   = 1'b0;
            mem_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instructions
// checked cycle by cycle against a per-instruction expected schedule.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_req;
    logic       mem_rdy;
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       mem_we;
    logic [1:0] rf_dst;
    logic [1:0] rf_wsrc;
    logic       alu_srcb;
    logic [2:0] alu_op;
    logic       ext_sign_src;
    logic       ext_lui;
    logic [1:0] pc_src;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_req      (mem_req),
        .mem_rdy      (mem_rdy),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .mem_we       (mem_we),
        .rf_dst       (rf_dst),
        .rf_wsrc      (rf_wsrc),
        .alu_srcb     (alu_srcb),
        .alu_op       (alu_op),
        .ext_sign_src (ext_sign_src),
        .ext_lui      (ext_lui),
        .pc_src       (pc_src),
        .state_o      (state_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One expected clock cycle of an instruction.
    typedef struct {
        logic [2:0] st;
        logic       rdy_any;
        logic       rdy;
        logic       mem_req;
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       mem_we;
        logic [1:0] rf_dst;
        logic [1:0] rf_wsrc;
        logic [1:0] pc_src;
        logic       op_care;
        logic [2:0] alu_op;
        logic       srcb_care;
        logic       alu_srcb;
    } cyc_t;

    cyc_t sched[$];

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '{st: st, rdy_any: 1'b1, default: '0};
        return c;
    endfunction

    // Expected cycle sequence derived from the instruction-level rules.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        cyc_t c;
        logic r, addu, subu, jr, ori, addiu, lui, lw, sw, beq, j, jal, alu;
        r     = (op == 6'b000000);
        addu  = r && (fn == 6'b100001);
        subu  = r && (fn == 6'b100011);
        jr    = r && (fn == 6'b001000);
        ori   = (op == 6'b001101);
        addiu = (op == 6'b001001);
        lui   = (op == 6'b001111);
        lw    = (op == 6'b100011);
        sw    = (op == 6'b101011);
        beq   = (op == 6'b000100);
        j     = (op == 6'b000010);
        jal   = (op == 6'b000011);
        alu   = addu || subu || ori || addiu || lui;
        sched.delete();

        for (int i = 0; i < fw; i++) begin
            c = blank(3'd0); c.rdy_any = 1'b0; c.rdy = 1'b0; c.mem_req = 1'b1;
            sched.push_back(c);
        end
        c = blank(3'd0); c.rdy_any = 1'b0; c.rdy = 1'b1; c.mem_req = 1'b1;
        c.ir_we = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'd0;
        sched.push_back(c);
        sched.push_back(blank(3'd1));

        c = blank(3'd2);
        if (alu || lw || sw) begin
            c.op_care = 1'b1; c.srcb_care = 1'b1;
            c.alu_op   = subu ? 3'd1 : ori ? 3'd2 : lui ? 3'd3 : 3'd0;
            c.alu_srcb = !r;
        end
        if (beq) begin
            c.op_care = 1'b1; c.alu_op = 3'd1; c.pc_we = z; c.pc_src = 2'd1;
        end
        if (j || jal) begin
            c.pc_we = 1'b1; c.pc_src = 2'd2;
        end
        if (jal) begin
            c.rf_we = 1'b1; c.rf_dst = 2'd2; c.rf_wsrc = 2'd2;
        end
        if (jr) begin
            c.pc_we = 1'b1; c.pc_src = 2'd3;
        end
        sched.push_back(c);

        if (lw || sw) begin
            for (int i = 0; i < mw; i++) begin
                c = blank(3'd3); c.rdy_any = 1'b0; c.rdy = 1'b0; c.mem_req = 1'b1;
                sched.push_back(c);
            end
            c = blank(3'd3); c.rdy_any = 1'b0; c.rdy = 1'b1; c.mem_req = 1'b1;
            c.mem_we = sw;
            sched.push_back(c);
        end
        if (alu || lw) begin
            c = blank(3'd4); c.rf_we = 1'b1;
            c.rf_dst  = r ? 2'd1 : 2'd0;
            c.rf_wsrc = lw ? 2'd1 : 2'd0;
            sched.push_back(c);
        end
    endtask

    // Drives one instruction and compares every cycle; limit < 0 runs it to completion.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int fw, input int mw, input int limit,
                       input bit hold_rdy);
        cyc_t c;
        build(op, fn, z, fw, mw);
        for (int i = 0; i < sched.size(); i++) begin
            if (limit >= 0 && i >= limit) break;
            c = sched[i];
            opcode  = op;
            funct   = fn;
            zero    = z;
            mem_rdy = c.rdy_any ? (hold_rdy ? 1'b1 : 1'($urandom_range(0, 1))) : c.rdy;
            @(negedge clk);
            check($sformatf("%s c%0d state", name, i), 32'(state_o), 32'(c.st));
            check($sformatf("%s c%0d mem_req", name, i), 32'(mem_req), 32'(c.mem_req));
            check($sformatf("%s c%0d pc_we", name, i), 32'(pc_we), 32'(c.pc_we));
            check($sformatf("%s c%0d ir_we", name, i), 32'(ir_we), 32'(c.ir_we));
            check($sformatf("%s c%0d rf_we", name, i), 32'(rf_we), 32'(c.rf_we));
            check($sformatf("%s c%0d mem_we", name, i), 32'(mem_we), 32'(c.mem_we));
            check($sformatf("%s c%0d ext_sign", name, i), 32'(ext_sign_src), 32'(op == 6'b001101));
            check($sformatf("%s c%0d ext_lui", name, i), 32'(ext_lui), 32'(op == 6'b001111));
            if (c.pc_we)
                check($sformatf("%s c%0d pc_src", name, i), 32'(pc_src), 32'(c.pc_src));
            if (c.rf_we) begin
                check($sformatf("%s c%0d rf_dst", name, i), 32'(rf_dst), 32'(c.rf_dst));
                check($sformatf("%s c%0d rf_wsrc", name, i), 32'(rf_wsrc), 32'(c.rf_wsrc));
            end
            if (c.op_care)
                check($sformatf("%s c%0d alu_op", name, i), 32'(alu_op), 32'(c.alu_op));
            if (c.srcb_care)
                check($sformatf("%s c%0d alu_srcb", name, i), 32'(alu_srcb), 32'(c.alu_srcb));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string name);
        check($sformatf("%s mem_req", name), 32'(mem_req), 32'd0);
        check($sformatf("%s pc_we", name), 32'(pc_we), 32'd0);
        check($sformatf("%s ir_we", name), 32'(ir_we), 32'd0);
        check($sformatf("%s rf_we", name), 32'(rf_we), 32'd0);
        check($sformatf("%s mem_we", name), 32'(mem_we), 32'd0);
    endtask

    logic [5:0] ops [0:10] = '{6'b000000, 6'b001101, 6'b001001, 6'b001111, 6'b100011,
                               6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000,
                               6'b000000};
    logic [5:0] fns [0:3]  = '{6'b100001, 6'b100011, 6'b001000, 6'b000000};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        reset   = 1'b1;
        opcode  = 6'd0;
        funct   = 6'd0;
        zero    = 1'b0;
        mem_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset state", 32'(state_o), 32'd0);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("ori",     6'b001101, 6'b000000, 1'b0, 0, 0, -1, 1'b1);
        run("lw",      6'b100011, 6'b010101, 1'b0, 3, 3, -1, 1'b0);
        run("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, -1, 1'b0);
        run("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, -1, 1'b0);
        run("jal",     6'b000011, 6'b000000, 1'b0, 1, 0, -1, 1'b0);
        run("bad_op",  6'b111111, 6'b000000, 1'b0, 0, 0, -1, 1'b0);
        run("lui",     6'b001111, 6'b000000, 1'b0, 0, 0, -1, 1'b0);
        run("addu",    6'b000000, 6'b100001, 1'b0, 2, 0, -1, 1'b0);
        run("jr",      6'b000000, 6'b001000, 1'b0, 0, 0, -1, 1'b0);
        run("bad_fn",  6'b000000, 6'b111111, 1'b0, 0, 0, -1, 1'b0);

        // sw stalled in MEM, then reset while memory reports ready.
        run("sw_rst", 6'b101011, 6'b000000, 1'b0, 0, 10, 5, 1'b0);
        reset   = 1'b1;
        mem_rdy = 1'b1;
        @(negedge clk);
        check("sw_rst mem state", 32'(state_o), 32'd3);
        check_quiet("sw_rst hold1");
        @(posedge clk);
        #1;
        mem_rdy = 1'b1;
        @(negedge clk);
        check("sw_rst fetch state", 32'(state_o), 32'd0);
        check_quiet("sw_rst hold2");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run("after_rst", 6'b101011, 6'b000000, 1'b0, 0, 1, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int k;
            k  = int'($urandom_range(0, 11));
            op = (k == 11) ? 6'($urandom_range(0, 63)) : ops[k];
            fn = (k == 11 || k == 10) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 3)];
            run($sformatf("rnd%0d", n), op, fn, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        @(negedge clk);
        check("final fetch", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
